// File: rtl/bch_gf_pkg.sv
// GF(2^M) helpers for the BCH column sequencer: elaboration-time constant math and shared types.
// Functions work on 32-bit words so one package serves any field degree up to 31.
package bch_gf_pkg;

  localparam int unsigned GfDefM    = 13;
  localparam logic [31:0] GfDefPoly = 32'h0000_001B;

  typedef logic [31:0] gf_word_t;

  typedef enum logic [0:0] {IDLE, RUN} state_e;

  // Multiply by alpha (x) and reduce modulo the primitive polynomial.
  function automatic gf_word_t gf_xtime(gf_word_t a, int unsigned m, gf_word_t poly);
    gf_word_t mask;
    gf_word_t r;
    mask = (gf_word_t'(1) << m) - gf_word_t'(1);
    r    = (a << 1) & mask;
    if (a[m-1]) r = r ^ (poly & mask);
    return r;
  endfunction

  // Product a*c; used at elaboration to build the constant-multiply XOR matrix columns.
  function automatic gf_word_t gf_cmul(gf_word_t a, gf_word_t c, int unsigned m, gf_word_t poly);
    gf_word_t r;
    r = '0;
    for (int i = 31; i >= 0; i--) begin
      if (i < int'(m)) begin
        r = gf_xtime(r, m, poly);
        if (c[i]) r = r ^ a;
      end
    end
    return r;
  endfunction

  // alpha^e by square-and-multiply; exponent reduced modulo the group order 2^m-1.
  function automatic gf_word_t gf_alpha_pow(int unsigned e, int unsigned m, gf_word_t poly);
    int unsigned ord;
    int unsigned ee;
    gf_word_t    r;
    ord = (32'd1 << m) - 32'd1;
    ee  = e % ord;
    r   = gf_word_t'(1);
    for (int i = 31; i >= 0; i--) begin
      r = gf_cmul(r, r, m, poly);
      if (ee[i]) r = gf_xtime(r, m, poly);
    end
    return r;
  endfunction

endpackage

// File: rtl/bch_gf_column_seq_if.sv
// Handshake bundle for bch_gf_column_seq: load side, beat side and done pulse.
// BCH_GF_ZERO_FLAG_EN adds the per-lane zero flags and their popcount.
interface bch_gf_column_seq_if #(
  parameter int unsigned M      = 13,
  parameter int unsigned LANES  = 8,
  parameter int unsigned NSTEPS = 4
);
  localparam int unsigned StepW = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;
  localparam int unsigned ZeroW = $clog2(LANES + 1);

  logic                 flush;
  logic                 in_valid;
  logic                 in_ready;
  logic [M-1:0]         in_b;
  logic                 out_valid;
  logic                 out_ready;
  logic [LANES*M-1:0]   out_p;
  logic [StepW-1:0]     out_step;
  logic                 out_last;
  logic                 done;
`ifdef BCH_GF_ZERO_FLAG_EN
  logic [LANES-1:0]     out_zero;
  logic [ZeroW-1:0]     out_nzero;
`endif

  modport master (
    output flush, in_valid, in_b, out_ready,
    input  in_ready, out_valid, out_p, out_step, out_last, done
`ifdef BCH_GF_ZERO_FLAG_EN
    , input out_zero, out_nzero
`endif
  );

  modport slave (
    input  flush, in_valid, in_b, out_ready,
    output in_ready, out_valid, out_p, out_step, out_last, done
`ifdef BCH_GF_ZERO_FLAG_EN
    , output out_zero, out_nzero
`endif
  );

endinterface

// File: rtl/gf_const_mult.sv
// Combinational multiply by a fixed GF(2^M) constant, realised as an XOR matrix.
module gf_const_mult import bch_gf_pkg::*; #(
  parameter int unsigned  M     = GfDefM,
  parameter logic [M-1:0] POLY  = M'(GfDefPoly),
  parameter logic [M-1:0] CONST = M'(1)
) (
  input  logic [M-1:0] a,
  output logic [M-1:0] p
);

  logic [M-1:0] term [M];

  // Column j is CONST * x^j; input bit j selects it.
  for (genvar j = 0; j < M; j++) begin : g_col
    localparam logic [M-1:0] Col =
      M'(gf_cmul(gf_word_t'(1) << j, gf_word_t'(CONST), M, gf_word_t'(POLY)));
    assign term[j] = a[j] ? Col : '0;
  end

  always_comb begin
    p = '0;
    for (int j = 0; j < M; j++) p = p ^ term[j];
  end

endmodule

// File: rtl/bch_gf_column_seq.sv
// Sequential BCH evaluation column: loads b, emits b*alpha^(E0+i+k*STEP) for NSTEPS beats.
// BCH_GF_ZERO_FLAG_EN adds registered per-lane zero flags and their popcount.
module bch_gf_column_seq import bch_gf_pkg::*; #(
  parameter int unsigned  M      = GfDefM,
  parameter logic [M-1:0] POLY   = M'(GfDefPoly),
  parameter int unsigned  LANES  = 8,
  parameter int unsigned  E0     = 1,
  parameter int unsigned  STEP   = 8,
  parameter int unsigned  NSTEPS = 4
) (
  input  logic               clk,
  input  logic               rst,
  bch_gf_column_seq_if.slave bus
);

  localparam int unsigned    StepW    = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;
  localparam logic [StepW-1:0] LastStep = StepW'(NSTEPS - 1);
  localparam logic [M-1:0]   StepMul  = M'(gf_alpha_pow(STEP, M, gf_word_t'(POLY)));

  state_e           state_q, state_d;
  logic [StepW-1:0] step_q, step_d;
  logic [M-1:0]     lane_q  [LANES];
  logic [M-1:0]     lane_d  [LANES];
  logic [M-1:0]     load_p  [LANES];
  logic [M-1:0]     scale_p [LANES];
  logic             done_q, done_d;
  logic             in_ready_q, out_valid_q, out_last_q;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    localparam logic [M-1:0] LoadMul = M'(gf_alpha_pow(E0 + i, M, gf_word_t'(POLY)));

    gf_const_mult #(
      .M     (M),
      .POLY  (POLY),
      .CONST (LoadMul)
    ) u_load (
      .a (bus.in_b),
      .p (load_p[i])
    );

    gf_const_mult #(
      .M     (M),
      .POLY  (POLY),
      .CONST (StepMul)
    ) u_scale (
      .a (lane_q[i]),
      .p (scale_p[i])
    );

    assign bus.out_p[i*M +: M] = lane_q[i];
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    lane_d  = lane_q;
    done_d  = 1'b0;
    if (bus.flush) begin
      // Lanes are left as-is; they are don't-care once out_valid drops.
      state_d = IDLE;
      step_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            state_d = RUN;
            step_d  = '0;
            lane_d  = load_p;
          end
        end
        RUN: begin
          if (bus.out_ready) begin
            if (step_q == LastStep) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              step_d = step_q + StepW'(1);
              lane_d = scale_p;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      step_q      <= '0;
      for (int i = 0; i < LANES; i++) lane_q[i] <= '0;
      done_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      lane_q      <= lane_d;
      done_q      <= done_d;
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == RUN);
      out_last_q  <= (state_d == RUN) && (step_d == LastStep);
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_step  = step_q;
  assign bus.out_last  = out_last_q;
  assign bus.done      = done_q;

`ifdef BCH_GF_ZERO_FLAG_EN
  localparam int unsigned ZeroW = $clog2(LANES + 1);

  logic [LANES-1:0] zero_q, zero_d;
  logic [ZeroW-1:0] nzero_q, nzero_d;

  always_comb begin
    zero_d  = '0;
    nzero_d = '0;
    for (int i = 0; i < LANES; i++) begin
      zero_d[i] = (lane_d[i] == '0);
      nzero_d   = nzero_d + ZeroW'(zero_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      zero_q  <= '1;
      nzero_q <= ZeroW'(LANES);
    end else begin
      zero_q  <= zero_d;
      nzero_q <= nzero_d;
    end
  end

  assign bus.out_zero  = zero_q;
  assign bus.out_nzero = nzero_q;
`endif

endmodule

// File: tb/tb_bch_gf_column_seq.sv
// Bench for bch_gf_column_seq: directed vectors plus a spec-level model checked every cycle.
module tb_bch_gf_column_seq;

  localparam int unsigned M      = 13;
  localparam int unsigned LANES  = 8;
  localparam int unsigned E0     = 1;
  localparam int unsigned STEP   = 8;
  localparam int unsigned NSTEPS = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bch_gf_column_seq_if #(.M(M), .LANES(LANES), .NSTEPS(NSTEPS)) bus ();
  bch_gf_column_seq_if #(.M(M), .LANES(1), .NSTEPS(1)) bus1 ();

  bch_gf_column_seq #(
    .M      (M),
    .POLY   (13'h001B),
    .LANES  (LANES),
    .E0     (E0),
    .STEP   (STEP),
    .NSTEPS (NSTEPS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  bch_gf_column_seq #(
    .M      (M),
    .POLY   (13'h001B),
    .LANES  (1),
    .E0     (0),
    .STEP   (STEP),
    .NSTEPS (1)
  ) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // b * alpha^e by repeated multiply-by-x over x^13+x^4+x^3+x+1.
  function automatic logic [12:0] ref_lane(logic [12:0] b, int unsigned e);
    logic [12:0] x;
    int unsigned n;
    x = b;
    n = e % 8191;
    for (int j = 0; j < int'(n); j++) x = (x << 1) ^ (x[12] ? 13'h001B : 13'h0000);
    return x;
  endfunction

  // Spec-level model: is a run active, which element, which beat.
  logic        started  = 1'b0;
  logic        m_active = 1'b0;
  logic        m_rdy    = 1'b0;
  logic        m_done   = 1'b0;
  logic [12:0] m_b      = '0;
  int          m_k      = 0;

  always @(posedge clk) begin
    started <= 1'b1;
    m_done  <= 1'b0;
    if (rst) begin
      m_active <= 1'b0;
      m_k      <= 0;
      m_rdy    <= 1'b0;
    end else if (bus.flush) begin
      m_active <= 1'b0;
      m_k      <= 0;
      m_rdy    <= 1'b1;
    end else if (!m_active) begin
      if (bus.in_valid && m_rdy) begin
        m_active <= 1'b1;
        m_b      <= bus.in_b;
        m_k      <= 0;
        m_rdy    <= 1'b0;
      end else begin
        m_rdy <= 1'b1;
      end
    end else if (bus.out_ready) begin
      if (m_k == int'(NSTEPS) - 1) begin
        m_active <= 1'b0;
        m_done   <= 1'b1;
        m_rdy    <= 1'b1;
      end else begin
        m_k   <= m_k + 1;
        m_rdy <= 1'b0;
      end
    end else begin
      m_rdy <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("out_valid", 32'(bus.out_valid), 32'(m_active));
      chk("in_ready", 32'(bus.in_ready), 32'(m_rdy));
      chk("done", 32'(bus.done), 32'(m_done));
      if (m_active) begin
        int nz;
        nz = 0;
        chk("out_step", 32'(bus.out_step), 32'(m_k));
        chk("out_last", 32'(bus.out_last), 32'(m_k == int'(NSTEPS) - 1));
        for (int i = 0; i < int'(LANES); i++) begin
          logic [12:0] e;
          e = ref_lane(m_b, E0 + i + m_k * STEP);
          if (e == 13'h0) nz++;
          chk("lane", 32'(bus.out_p[i*M +: M]), 32'(e));
`ifdef BCH_GF_ZERO_FLAG_EN
          chk("out_zero_bit", 32'(bus.out_zero[i]), 32'(e == 13'h0));
`endif
        end
`ifdef BCH_GF_ZERO_FLAG_EN
        chk("out_nzero", 32'(bus.out_nzero), 32'(nz));
`endif
      end else begin
        chk("out_last_idle", 32'(bus.out_last), 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.flush = 1'b0;  bus.in_valid = 1'b0;  bus.in_b = '0;  bus.out_ready = 1'b1;
    bus1.flush = 1'b0; bus1.in_valid = 1'b0; bus1.in_b = '0; bus1.out_ready = 1'b1;
    tick();
    @(negedge clk);
    chk("rst_in_ready_low", 32'(bus.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    @(negedge clk);
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("post_rst_step", 32'(bus.out_step), 32'd0);

    // in_b = 1: beat 0 lanes are alpha^1..alpha^8.
    bus.in_b = 13'h0001; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < int'(LANES); i++) begin
      logic [12:0] one;
      one = 13'h0001;
      chk("t1_beat0_lane", 32'(bus.out_p[i*M +: M]), 32'(one << (i + 1)));
    end
    tick();
    @(negedge clk);
    chk("t1_beat1_lane0", 32'(bus.out_p[0 +: 13]), 32'h0200);
    chk("t1_beat1_lane7", 32'(bus.out_p[7*13 +: 13]), 32'h00D8);
    chk("t1_beat1_step", 32'(bus.out_step), 32'd1);
    tick(); tick();
    @(negedge clk);
    chk("t1_beat3_last", 32'(bus.out_last), 32'd1);
    tick();
    @(negedge clk);
    chk("t1_done", 32'(bus.done), 32'd1);
    chk("t1_done_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    @(negedge clk);
    chk("t1_done_single", 32'(bus.done), 32'd0);

    // Zero element: all lanes zero for every beat.
    bus.in_b = 13'h0000; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("t2_lanes_zero", 32'(|bus.out_p), 32'd0);
`ifdef BCH_GF_ZERO_FLAG_EN
    chk("t2_out_zero", 32'(bus.out_zero), 32'h00FF);
    chk("t2_out_nzero", 32'(bus.out_nzero), 32'd8);
`endif
    repeat (4) tick();

    // Back-pressure at beat 2 for five cycles.
    bus.in_b = 13'h0ABC; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick(); tick();
    bus.out_ready = 1'b0;
    repeat (5) tick();
    @(negedge clk);
    chk("t3_hold_step", 32'(bus.out_step), 32'd2);
    chk("t3_hold_last", 32'(bus.out_last), 32'd0);
    chk("t3_hold_lane0", 32'(bus.out_p[0 +: 13]), 32'(ref_lane(13'h0ABC, 17)));
    bus.out_ready = 1'b1;
    tick(); tick();
    @(negedge clk);
    chk("t3_done", 32'(bus.done), 32'd1);

    // Flush during beat 1 with a competing load.
    bus.in_b = 13'h1F00; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    bus.flush = 1'b1; bus.in_valid = 1'b1; bus.in_b = 13'h0777;
    tick();
    bus.flush = 1'b0;
    @(negedge clk);
    chk("t4_flush_valid", 32'(bus.out_valid), 32'd0);
    chk("t4_flush_done", 32'(bus.done), 32'd0);
    chk("t4_flush_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("t4_reload_valid", 32'(bus.out_valid), 32'd1);
    chk("t4_reload_lane0", 32'(bus.out_p[0 +: 13]), 32'h0EEE);
    repeat (4) tick();
    @(negedge clk);
    chk("t4_done", 32'(bus.done), 32'd1);

    // Single-beat, single-lane, E0 = 0 instance.
    bus1.in_b = 13'h1234; bus1.in_valid = 1'b1;
    tick();
    bus1.in_valid = 1'b0;
    @(negedge clk);
    chk("t5_valid", 32'(bus1.out_valid), 32'd1);
    chk("t5_p", 32'(bus1.out_p), 32'h1234);
    chk("t5_last", 32'(bus1.out_last), 32'd1);
    chk("t5_step", 32'(bus1.out_step), 32'd0);
    tick();
    @(negedge clk);
    chk("t5_done", 32'(bus1.done), 32'd1);
    chk("t5_idle", 32'(bus1.out_valid), 32'd0);

    // Random traffic with a reset pulse mid-stream.
    for (int c = 0; c < 400; c++) begin
      if (c == 200) begin
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.flush = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
        @(negedge clk);
        chk("t6_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("t6_rst_ready", 32'(bus.in_ready), 32'd1);
      end
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.in_b      = 13'($urandom);
      bus.out_ready = 1'($urandom_range(0, 3) != 0);
      bus.flush     = ($urandom_range(0, 15) == 0);
      tick();
    end
    bus.in_valid = 1'b0; bus.flush = 1'b0; bus.out_ready = 1'b1;
    repeat (6) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bch_gf_column_seq.md
# bch_gf_column_seq

Parametrised, sequential successor of the fixed GF(2^13) constant-multiplier columns used in the BCH Euclidean decoder. The block loads one field element `b` and presents LANES products `b·α^(E0+i)` as registered outputs. It then re-scales every lane by the constant α^STEP once per accepted output beat, for NSTEPS beats. This is the evaluation-column structure the Chien search and syndrome engines need. The block sits between the key-equation solver output registers and the root/syndrome accumulators, with valid/ready flow control on both sides.

## Interface
Parameters:
- `M`, 13: field degree; all elements are `M` bits.
- `POLY`, 13'h001B: low `M` bits of the primitive polynomial. The x^M term is implicit; default is x^13+x^4+x^3+x+1.
- `LANES`, 8: number of product lanes, at least 1.
- `E0`, 1: exponent of the lane-0 constant. Lane i constant is α^(E0+i).
- `STEP`, 8: per-beat re-scale exponent, applied to all lanes.
- `NSTEPS`, 4: beats per load, at least 1.

Ports:
- `clk`, in, 1: clock. All state changes on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `flush`, in, 1: abort the current run and return to IDLE.
- `in_valid`, in, 1: `in_b` is valid.
- `in_ready`, out, 1: the block can accept a load.
- `in_b`, in, M: element to load.
- `out_valid`, out, 1: the lane products are valid.
- `out_ready`, in, 1: the consumer accepts the current beat.
- `out_p`, out, LANES*M: lane i occupies bits `[i*M +: M]`.
- `out_step`, out, $clog2(NSTEPS): beat index of the current output.
- `out_last`, out, 1: the current beat is beat NSTEPS-1.
- `done`, out, 1: one-cycle pulse after the last beat is accepted.

## Operation
- Field arithmetic is GF(2^M) modulo `POLY`. Addition is XOR. Multiplying by a constant is a fixed XOR matrix derived at elaboration. There are no general multipliers.
- States are IDLE and RUN.
- IDLE:
  - `in_ready=1`, `out_valid=0`.
  - On `in_valid & in_ready & !flush`: lane i is loaded with `in_b·α^(E0+i)`, step is set to 0, and the state moves to RUN.
- RUN:
  - `out_valid=1`, `in_ready=0`.
  - `out_last = (step==NSTEPS-1)`.
- On `out_valid & out_ready` in RUN:
  - If `out_last`: the state moves to IDLE and `done` pulses in the next cycle.
  - Otherwise: every lane updates to `lane·α^STEP` and step increments.
- Outputs hold stable while `out_valid & !out_ready`.
- Beat k, lane i equals `in_b·α^(E0+i+k·STEP)`. Exponents reduce modulo 2^M−1.
- `flush` has priority over everything:
  - The state moves to IDLE and step goes to 0.
  - Lane registers keep their values but are don't-care.
  - `done` is not pulsed.
  - A simultaneous `in_valid` is not accepted.
- `in_b = 0` gives zero on all lanes for every beat. This is legal.
- Reset values:
  - State is IDLE and all lanes and step are 0.
  - `out_valid=0`, `out_last=0`, `done=0`.
  - `in_ready=0` while `rst` is high, and 1 from the first cycle after `rst` falls.

## Timing
- Load latency: if a load is accepted at edge t, the first beat is valid after edge t, with `out_valid` high in cycle t+1.
- Beat throughput is one beat per cycle when `out_ready` is held high.
- `done` goes high the cycle after the last handshake, with `in_ready` high in that same cycle. The next load can be accepted in that cycle.
- Minimum load-to-load spacing is NSTEPS+1 cycles.
- When NSTEPS=1, `out_last` is high on the first beat and no re-scale occurs.
- Step wrap: the counter never exceeds NSTEPS-1. It resets to 0 on load.
- All outputs are driven directly from registers or from a state decode. There is no combinational path from `in_*` to `out_*`.

## Configuration
- `BCH_GF_ZERO_FLAG_EN`:
  - When defined, the block adds `out_zero` (out, LANES): bit i = (lane i == 0), registered alongside the lanes.
  - It also adds `out_nzero` (out, $clog2(LANES+1)): the popcount of `out_zero`.
  - These flags are used for Chien root detection.
- When the macro is undefined, these ports and their logic are absent. All other behaviour is identical.

## Structure
- Package `bch_gf_pkg` holds:
  - the defaults for `M` and `POLY`;
  - the function `gf_xtime`;
  - the function `gf_alpha_pow(e)`, evaluated at elaboration;
  - the function `gf_cmul(a, c)`, which returns the constant-multiply XOR matrix result;
  - the state enum `{IDLE, RUN}`.
- Sub-module `gf_const_mult` is purely combinational, with parameters `M`, `POLY` and `CONST`.
  - LANES instances handle the load products.
  - LANES instances of the α^STEP constant handle the re-scale products.

## Test plan
- Default parameters, `in_b=0x0001`, `out_ready=1`:
  - Beat 0 lanes are 0x0002, 0x0004, …, 0x0100.
  - Beat 1 lane 0 is 0x0200 and lane 7 is 0x00D8 (α^16).
  - `done` pulses in the cycle after beat 3.
- `in_b=0x0000`:
  - All lanes read 0 on all 4 beats.
  - With `BCH_GF_ZERO_FLAG_EN`, `out_zero=8'hFF` and `out_nzero=8`.
- Hold `out_ready=0` for 5 cycles at beat 2: `out_p`, `out_step=2` and `out_last=0` stay stable, and no re-scale occurs.
- Assert `flush` during beat 1, together with `in_valid`:
  - The next cycle is IDLE with `out_valid=0` and no `done`.
  - The load is taken one cycle later.
- NSTEPS=1, LANES=1, E0=0, `in_b=0x1234`: a single beat of 0x1234 with `out_last=1`, and `done` pulses in the next cycle.
- Random `in_b`, random `out_ready`, and `rst` pulsed mid-run: every beat matches the package reference model, and after reset `out_valid=0` and `in_ready=1`.
